// File: rtl/cache_memory.sv
// ---------------------------------------------------------------------------
// cache_memory
//
// Four-way set-associative, write-back, write-allocate data cache together
// with the block memory behind it. The CPU sees a single word port; misses
// stall the CPU while the cache writes back a dirty victim (if needed) and
// then fetches the whole block from the internal memory.
//
// CPU handshake: the CPU raises c_read_i or c_wr_i with address_i (and
// c_write_data_i) and holds them unchanged while c_busywait_o is high. A
// read completes in the first cycle c_busywait_o is low (c_data_o valid in
// that cycle). A write commits at the first rising edge where c_busywait_o
// is low. If both requests are high, the read wins.
//
// Ports:
//   clk_i          - clock, all state updates on the rising edge
//   reset_i        - synchronous, active-low reset
//   address_i      - byte address
//   c_read_i       - read request (level, held while stalled)
//   c_wr_i         - write request (level, held while stalled)
//   c_write_data_i - write data
//   c_busywait_o   - stall to the CPU
//   c_data_o       - read data, 0 unless the current read hits
//   dbg_state_o    - current controller state (IDLE/WRITEBACK/FETCH/UPDATE)
// ---------------------------------------------------------------------------
module cache_memory #(
  parameter int BLOCK_SIZE      = 2,
  parameter int LINE_SIZE       = 32,
  parameter int ADDRESS_SIZE    = 32,
  parameter int INDEX_BITS      = 4,
  parameter int MEM_BLOCKS_LOG2 = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [ADDRESS_SIZE-1:0] address_i,
  input  logic                    c_read_i,
  input  logic                    c_wr_i,
  input  logic [LINE_SIZE-1:0]    c_write_data_i,
  output logic                    c_busywait_o,
  output logic [LINE_SIZE-1:0]    c_data_o,
  output logic [1:0]              dbg_state_o
);

  localparam int WAYS      = 4;
  localparam int WORDS     = 1 << BLOCK_SIZE;
  localparam int BLK_W     = LINE_SIZE * WORDS;
  localparam int SETS      = 1 << INDEX_BITS;
  localparam int OFF_BITS  = $clog2(LINE_SIZE / 8);
  localparam int IDX_LSB   = OFF_BITS + BLOCK_SIZE;
  localparam int TAG_LSB   = IDX_LSB + INDEX_BITS;
  localparam int TAG_W     = ADDRESS_SIZE - TAG_LSB;
  localparam int BADDR_W   = TAG_W + INDEX_BITS;
  localparam int MEM_DEPTH = 1 << MEM_BLOCKS_LOG2;
  localparam int CNT_W     = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Cache storage. Status bits are kept per set as a 4-bit way vector.
  // -------------------------------------------------------------------------
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [WAYS-1:0]  use_q   [SETS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [BLK_W-1:0] data_q  [WAYS][SETS];

  state_t           state_q, state_d;
  logic [1:0]       vic_q, vic_d;
  logic [BLK_W-1:0] fill_q;

  // Memory side
  logic                       mem_rd, mem_wr;
  logic [MEM_BLOCKS_LOG2-1:0] mem_addr;
  logic [BLK_W-1:0]           mem_wdata;
  logic [BLK_W-1:0]           mem_q [MEM_DEPTH];
  logic [BLK_W-1:0]           mem_rdata_q;
  logic                       mem_done_q;
  logic [CNT_W-1:0]           mem_cnt_q;

  // -------------------------------------------------------------------------
  // Address split
  // -------------------------------------------------------------------------
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [BLOCK_SIZE-1:0] req_word;
  logic                  req;
  logic                  wr_only;

  assign req_word = address_i[OFF_BITS +: BLOCK_SIZE];
  assign req_idx  = address_i[IDX_LSB +: INDEX_BITS];
  assign req_tag  = address_i[TAG_LSB +: TAG_W];
  assign req      = c_read_i | c_wr_i;
  assign wr_only  = c_wr_i & ~c_read_i;

  // -------------------------------------------------------------------------
  // Hit detection and data select
  // -------------------------------------------------------------------------
  logic [WAYS-1:0]      hit_vec;
  logic                 hit;
  logic [1:0]           hit_way;
  logic [BLK_W-1:0]     hit_block;
  logic [BLK_W-1:0]     wr_block;
  logic [LINE_SIZE-1:0] rd_word;

  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag);
    end
  end

  assign hit = |hit_vec;

  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = 2'(w);
    end
  end

  // Selected word for reads, and the hit block with the write word merged in.
  always_comb begin
    hit_block = data_q[hit_way][req_idx];
    rd_word   = '0;
    wr_block  = hit_block;
    for (int w = 0; w < WORDS; w++) begin
      if (req_word == BLOCK_SIZE'(w)) begin
        rd_word                            = hit_block[w*LINE_SIZE +: LINE_SIZE];
        wr_block[w*LINE_SIZE +: LINE_SIZE] = c_write_data_i;
      end
    end
  end

  assign c_data_o = (c_read_i && hit) ? rd_word : '0;

  // -------------------------------------------------------------------------
  // Victim choice: lowest invalid way, else lowest way not recently used.
  // -------------------------------------------------------------------------
  logic [1:0] vic_way;
  logic       vic_found;

  always_comb begin
    vic_way   = '0;
    vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!vic_found && !valid_q[req_idx][w]) begin
        vic_way   = 2'(w);
        vic_found = 1'b1;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!vic_found && !use_q[req_idx][w]) begin
        vic_way   = 2'(w);
        vic_found = 1'b1;
      end
    end
  end

  // MRU bits: mark the accessed way; once every way is marked, restart the
  // history with only the accessed way set.
  function automatic logic [WAYS-1:0] use_next(input logic [WAYS-1:0] u,
                                                input logic [1:0] way);
    logic [WAYS-1:0] one_hot;
    logic [WAYS-1:0] n;
    one_hot = WAYS'(1) << way;
    n       = u | one_hot;
    if (&n) n = one_hot;
    return n;
  endfunction

  // -------------------------------------------------------------------------
  // Controller: next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    vic_d        = vic_q;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    c_busywait_o = 1'b1;
    case (state_q)
      IDLE: begin
        c_busywait_o = req & ~hit;
        if (req && !hit) begin
          vic_d = vic_way;
          if (valid_q[req_idx][vic_way] && dirty_q[req_idx][vic_way]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FETCH;
          end
        end
      end
      WRITEBACK: begin
        mem_wr = 1'b1;
        if (mem_done_q) state_d = FETCH;
      end
      FETCH: begin
        mem_rd = 1'b1;
        if (mem_done_q) state_d = UPDATE;
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dbg_state_o = state_q;

  // Write-back goes to the victim's own block address; fetch uses the request.
  logic [BADDR_W-1:0] wb_baddr;
  assign wb_baddr  = {tag_q[vic_q][req_idx], req_idx};
  assign mem_addr  = (state_q == WRITEBACK) ? wb_baddr[MEM_BLOCKS_LOG2-1:0]
                                            : address_i[IDX_LSB +: MEM_BLOCKS_LOG2];
  assign mem_wdata = data_q[vic_q][req_idx];

  // Address bits the memory does not decode.
  logic unused_bits;
  assign unused_bits = ^{address_i[OFF_BITS-1:0], wb_baddr};

  // -------------------------------------------------------------------------
  // Cache state registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      vic_q   <= '0;
      fill_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        use_q[s]   <= '0;
      end
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          tag_q[w][s]  <= '0;
          data_q[w][s] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      vic_q   <= vic_d;

      if (state_q == FETCH && mem_done_q) fill_q <= mem_rdata_q;

      if (state_q == IDLE && req && hit) begin
        use_q[req_idx] <= use_next(use_q[req_idx], hit_way);
        if (wr_only) begin
          data_q[hit_way][req_idx]  <= wr_block;
          dirty_q[req_idx][hit_way] <= 1'b1;
        end
      end

      if (state_q == UPDATE) begin
        data_q[vic_q][req_idx]  <= fill_q;
        tag_q[vic_q][req_idx]   <= req_tag;
        valid_q[req_idx][vic_q] <= 1'b1;
        dirty_q[req_idx][vic_q] <= 1'b0;
        use_q[req_idx]          <= use_next(use_q[req_idx], vic_q);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Block memory. A request is counted from the first edge that sees it; on
  // the MEM_LATENCY-th counted edge the access happens and done pulses for
  // one cycle. The edge where done is high ignores the (stale) request so
  // that the next request starts counting cleanly one edge later.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      mem_done_q  <= 1'b0;
      mem_cnt_q   <= '0;
      mem_rdata_q <= '0;
      for (int b = 0; b < MEM_DEPTH; b++) begin
        for (int w = 0; w < WORDS; w++) begin
          mem_q[b][w*LINE_SIZE +: LINE_SIZE] <= LINE_SIZE'((b << BLOCK_SIZE) | w);
        end
      end
    end else begin
      mem_done_q <= 1'b0;
      if ((mem_rd || mem_wr) && !mem_done_q) begin
        if (mem_cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
          mem_cnt_q  <= '0;
          mem_done_q <= 1'b1;
          if (mem_wr) begin
            mem_q[mem_addr] <= mem_wdata;
          end else begin
            mem_rdata_q <= mem_q[mem_addr];
          end
        end else begin
          mem_cnt_q <= mem_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_memory.sv
// ---------------------------------------------------------------------------
// tb_cache_memory
//
// Bench for cache_memory. A flat word model of memory (12-bit address space,
// reset to word address) gives the expected read data: whatever the cache
// does internally, a read must return the last value written to that word.
// Expected read data is queued when a read is driven and compared when the
// DUT drops c_busywait_o. Stall lengths in the directed part are worked out
// by hand from the hit/miss/dirty history of each set.
// ---------------------------------------------------------------------------
module tb_cache_memory;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic [31:0] address = '0;
  logic        c_read  = 1'b0;
  logic        c_wr    = 1'b0;
  logic [31:0] c_write_data = '0;
  logic        c_busywait;
  logic [31:0] c_data;
  logic [1:0]  dbg_state;

  cache_memory dut (
    .clk_i          (clk),
    .reset_i        (reset_n),
    .address_i      (address),
    .c_read_i       (c_read),
    .c_wr_i         (c_wr),
    .c_write_data_i (c_write_data),
    .c_busywait_o   (c_busywait),
    .c_data_o       (c_data),
    .dbg_state_o    (dbg_state)
  );

  // Scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] mem_model [1024];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) mem_model[i] = i;
    exp_q.delete();
  endtask

  // Called right after a request is driven; counts the rising edges after
  // which the DUT still stalls.
  task automatic wait_not_busy(output int stall, output bit timeout);
    stall   = 0;
    timeout = 1'b0;
    #1;
    while (c_busywait && !timeout) begin
      @(posedge clk);
      #1;
      if (c_busywait) stall++;
      if (stall > 200) timeout = 1'b1;
    end
  endtask

  // Drivers
  task automatic cpu_read(input string tag, input logic [31:0] addr, output int stall);
    bit          to;
    logic [31:0] exp;
    @(negedge clk);
    address = addr;
    c_read  = 1'b1;
    c_wr    = 1'b0;
    exp_q.push_back(mem_model[addr[11:2]]);
    wait_not_busy(stall, to);
    exp = exp_q.pop_front();
    if (to) check_eq({tag, "_timeout"}, 32'(c_busywait), 32'd0);
    else    check_eq(tag, c_data, exp);
    @(posedge clk);
    #1;
    c_read = 1'b0;
  endtask

  task automatic cpu_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           output int stall);
    bit to;
    @(negedge clk);
    address      = addr;
    c_write_data = data;
    c_wr         = 1'b1;
    c_read       = 1'b0;
    mem_model[addr[11:2]] = data;
    wait_not_busy(stall, to);
    if (to) check_eq({tag, "_timeout"}, 32'(c_busywait), 32'd0);
    @(posedge clk);  // write commits here
    #1;
    c_wr = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    c_read  = 1'b0;
    c_wr    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [31:0] a;
    logic [31:0] d;
    int ok;

    model_reset();
    apply_reset();
    #1;
    check_eq("rst_busy", 32'(c_busywait), 32'd0);
    check_eq("rst_data", c_data, 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);

    // Clean miss then hit in the same block
    cpu_read("rd_0E", 32'h0E, st);        check_eq("rd_0E_stall", st, 6);
    cpu_read("rd_0A", 32'h0A, st);        check_eq("rd_0A_stall", st, 0);
    cpu_read("rd_16", 32'h16, st);        check_eq("rd_16_stall", st, 6);

    // Write hit, read back
    cpu_write("wr_1A", 32'h1A, 32'h38, st); check_eq("wr_1A_stall", st, 0);
    cpu_read("rd_1A", 32'h1A, st);        check_eq("rd_1A_stall", st, 0);

    // Fill ways 1..3 of set 1
    cpu_read("rd_11A", 32'h11A, st);      check_eq("rd_11A_stall", st, 6);
    cpu_read("rd_21A", 32'h21A, st);      check_eq("rd_21A_stall", st, 6);
    cpu_read("rd_31A", 32'h31A, st);      check_eq("rd_31A_stall", st, 6);
    cpu_write("wr_31A", 32'h31A, 32'hA3, st); check_eq("wr_31A_stall", st, 0);
    cpu_write("wr_21A", 32'h21A, 32'hA2, st); check_eq("wr_21A_stall", st, 0);
    cpu_write("wr_11A", 32'h11A, 32'hA1, st); check_eq("wr_11A_stall", st, 0);

    // Dirty eviction of way 0, then its block comes back from memory
    cpu_read("rd_41A", 32'h41A, st);      check_eq("rd_41A_stall", st, 11);
    cpu_read("rerd_1A", 32'h1A, st);      check_eq("rerd_1A_stall", st, 11);
    cpu_read("rerd_11A", 32'h11A, st);    check_eq("rerd_11A_stall", st, 11);

    // Write miss allocates, then completes as a hit
    cpu_write("wr_60", 32'h60, 32'h55, st); check_eq("wr_60_stall", st, 6);
    cpu_read("rd_60", 32'h60, st);        check_eq("rd_60_stall", st, 0);

    // Reset in the middle of a fetch
    @(negedge clk);
    address = 32'h4E;
    c_read  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    c_read  = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_state", 32'(dbg_state), 32'd0);
    check_eq("midrst_busy", 32'(c_busywait), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    cpu_read("post_rst_0E", 32'h0E, st);  check_eq("post_rst_0E_stall", st, 6);

    // Random traffic over two sets with many tags to force evictions
    for (int i = 0; i < 40; i++) begin
      a = {20'd0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        cpu_write("rnd_wr", a, d, st);
      end else begin
        cpu_read("rnd_rd", a, st);
      end
      ok = (st == 0 || st == 6 || st == 11) ? 1 : 0;
      check_eq("rnd_stall_len", ok, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
